// File: rtl/tnn_compress_pkg.sv
// Shared constants and state encoding for the threshold-compressor sequencer.
package tnn_compress_pkg;

   localparam int          GROUP_SIZE     = 5;
   localparam int          BYTES_PER_WORD = 4;
   localparam logic [31:0] PAD_THR        = 32'h0001_FFFF;

   typedef enum logic [3:0] {
      TC_IDLE,
      TC_FETCH,
      TC_WAIT_THR,
      TC_WAIT_IN,
      TC_PAD,
      TC_CAPTURE,
      TC_STORE,
      TC_WAIT_ST,
      TC_DONE
   } tc_state_e;

endpackage

// File: rtl/tc_word_packer.sv
// Packs encoded bytes into a 32-bit store word and tracks its byte-enable mask.
// Lane write and clear take effect on the next edge; no backpressure.
module tc_word_packer
   import tnn_compress_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_clr,
   input  logic        i_wr,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic [3:0]  o_be,
   output logic        o_full
);

   logic [1:0]  r_lane;
   logic [31:0] r_word;
   logic [3:0]  r_be;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lane <= '0;
         r_word <= '0;
         r_be   <= '0;
      end else if (i_clr) begin
         r_lane <= '0;
         r_word <= '0;
         r_be   <= '0;
      end else if (i_wr) begin
         r_word[8*r_lane +: 8] <= i_byte;
         r_be[r_lane]          <= 1'b1;
         r_lane                <= r_lane + 2'd1;
      end
   end

   // High while the next write lands in the last lane of the word.
   assign o_full = (r_lane == 2'(BYTES_PER_WORD - 1));
   assign o_word = r_word;
   assign o_be   = r_be;

endmodule

// File: rtl/threshold_compress_ctrl.sv
// Sequencer for one threshold compressor: fetches thresholds, streams activations,
// pads partial groups and stores packed code bytes over a single shared memory port.
module threshold_compress_ctrl
   import tnn_compress_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  n_act_i,
   input  logic [ADDR_WIDTH-1:0] thr_base_i,
   input  logic [ADDR_WIDTH-1:0] out_base_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  in_valid_i,
   input  logic [31:0]           in_data_i,
   output logic                  in_ready_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [31:0]           mem_rdata_i,
   output logic                  cmp_en_o,
   output logic [31:0]           cmp_data_o,
   output logic [31:0]           cmp_thr_o,
   input  logic [7:0]            cmp_byte_i
);

   localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
   localparam logic [2:0]           GRP_LAST = 3'(GROUP_SIZE - 1);

   tc_state_e             r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0]  r_n, r_idx, r_word_idx;
   logic [2:0]            r_grp;
   logic [ADDR_WIDTH-1:0] r_thr_base, r_out_base;
   logic [31:0]           r_thr;
   logic                  r_done;
   logic                  w_clr, w_capture, w_full, w_all;
   logic [31:0]           w_pack;
   logic [3:0]            w_be;
   logic [ADDR_WIDTH-1:0] w_thr_addr, w_out_addr;

   assign w_thr_addr = r_thr_base + ADDR_WIDTH'({r_idx, 2'b00});
   assign w_out_addr = r_out_base + ADDR_WIDTH'({r_word_idx, 2'b00});
   assign w_all      = (r_idx == r_n);
   assign busy_o     = (r_state != TC_IDLE);
   assign done_o     = r_done;

   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_capture   = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      in_ready_o  = 1'b0;
      cmp_en_o    = 1'b0;
      cmp_data_o  = '0;
      cmp_thr_o   = '0;
      case (r_state)
         TC_IDLE: if (start_i) begin
            w_clr       = 1'b1;
            w_state_nxt = (n_act_i != '0) ? TC_FETCH : TC_DONE;
         end
         TC_FETCH: begin
            mem_req_o  = 1'b1;
            mem_addr_o = w_thr_addr;
            if (mem_gnt_i) w_state_nxt = TC_WAIT_THR;
         end
         TC_WAIT_THR: if (mem_rvalid_i) w_state_nxt = TC_WAIT_IN;
         TC_WAIT_IN: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               cmp_en_o   = 1'b1;
               cmp_data_o = in_data_i;
               cmp_thr_o  = r_thr;
               if (r_grp == GRP_LAST)        w_state_nxt = TC_CAPTURE;
               else if (r_idx == r_n - ONE)  w_state_nxt = TC_PAD;
               else                          w_state_nxt = TC_FETCH;
            end
         end
         // Zero data against a +/-1 window encodes activation 0 and completes the group.
         TC_PAD: begin
            cmp_en_o  = 1'b1;
            cmp_thr_o = PAD_THR;
            if (r_grp == GRP_LAST) w_state_nxt = TC_CAPTURE;
         end
         TC_CAPTURE: begin
            w_capture   = 1'b1;
            w_state_nxt = (w_full || w_all) ? TC_STORE : TC_FETCH;
         end
         TC_STORE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = w_out_addr;
            mem_be_o    = w_be;
            mem_wdata_o = w_pack;
            if (mem_gnt_i) w_state_nxt = TC_WAIT_ST;
         end
         TC_WAIT_ST: if (mem_rvalid_i) begin
            w_clr       = 1'b1;
            w_state_nxt = w_all ? TC_DONE : TC_FETCH;
         end
         TC_DONE: w_state_nxt = TC_IDLE;
         default: w_state_nxt = TC_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= TC_IDLE;
         r_n        <= '0;
         r_idx      <= '0;
         r_word_idx <= '0;
         r_grp      <= '0;
         r_thr_base <= '0;
         r_out_base <= '0;
         r_thr      <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == TC_DONE);
         case (r_state)
            TC_IDLE: if (start_i) begin
               r_n        <= n_act_i;
               r_thr_base <= thr_base_i & ~ADDR_WIDTH'(3);
               r_out_base <= out_base_i & ~ADDR_WIDTH'(3);
               r_idx      <= '0;
               r_word_idx <= '0;
               r_grp      <= '0;
            end
            TC_WAIT_THR: if (mem_rvalid_i) r_thr <= mem_rdata_i;
            TC_WAIT_IN: if (in_valid_i) begin
               r_idx <= r_idx + ONE;
               r_grp <= r_grp + 3'd1;
            end
            TC_PAD:     r_grp <= r_grp + 3'd1;
            TC_CAPTURE: r_grp <= '0;
            TC_WAIT_ST: if (mem_rvalid_i) r_word_idx <= r_word_idx + ONE;
            default: ;
         endcase
      end
   end

   tc_word_packer u_packer (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clr   (w_clr),
      .i_wr    (w_capture),
      .i_byte  (cmp_byte_i),
      .o_word  (w_pack),
      .o_be    (w_be),
      .o_full  (w_full)
   );

endmodule

// File: tb/tb_threshold_compress_ctrl.sv
// Random-stimulus bench: memory slave, accumulator source and compressor stand-in around the sequencer.
module tb_threshold_compress_ctrl;
   import tnn_compress_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] n_act_i = '0;
   logic [31:0] thr_base_i = '0, out_base_i = '0;
   logic        busy_o, done_o;
   logic        in_valid_i = 1'b0;
   logic [31:0] in_data_i = '0;
   logic        in_ready_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        cmp_en_o;
   logic [31:0] cmp_data_o, cmp_thr_o;
   logic [7:0]  cmp_byte_i;

   always #5 clk_i = ~clk_i;

   threshold_compress_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .n_act_i(n_act_i),
      .thr_base_i(thr_base_i), .out_base_i(out_base_i), .busy_o(busy_o), .done_o(done_o),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .cmp_en_o(cmp_en_o), .cmp_data_o(cmp_data_o),
      .cmp_thr_o(cmp_thr_o), .cmp_byte_i(cmp_byte_i)
   );

   int n_checks = 0, n_fail = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Job context and observation logs
   logic [31:0] g_dat [64];
   logic [31:0] g_thr [64];
   int          g_n, g_t0;
   logic [31:0] g_thr_eff, g_out_eff;
   int          lat_max = 0, gap_pct = 0;
   logic [31:0] in_q[$];
   logic [31:0] ld_q[$];
   logic [67:0] st_q[$];
   int          cyc = 0, cmp_cnt, pad_cnt, pad_zero, done_cnt, done_cyc, req_cnt;
   bit          mon_hs = 1'b0;
   int          wgt[5] = '{81, 27, 9, 3, 1};

   // Ternary activation: +1 above hi, -1 below lo, else 0 (signed compare).
   function automatic int trit(input logic [31:0] d, input logic [31:0] thr);
      int sd, hi, lo;
      sd = $signed(d);
      hi = $signed(thr[31:16]);
      lo = $signed(thr[15:0]);
      return (sd > hi) ? 1 : (sd < lo) ? -1 : 0;
   endfunction

   // Expected code byte j: base-3 digits (trit+1), first activation most significant; pads are 0.
   function automatic logic [7:0] exp_byte(input int j);
      int v = 0;
      for (int k = 0; k < 5; k++) begin
         int i = 5*j + k;
         int t = (i < g_n) ? trit(g_dat[i], g_thr[i]) : 0;
         v += (t + 1) * wgt[k];
      end
      return 8'(v);
   endfunction

   // Compressor stand-in: accumulates 5 digits, presents the byte one cycle after the 5th enable.
   int cs_cnt, cs_acc;
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cs_cnt <= 0; cs_acc <= 0; cmp_byte_i <= '0;
      end else if (cmp_en_o) begin
         if (cs_cnt == GROUP_SIZE - 1) begin
            cmp_byte_i <= 8'(cs_acc*3 + trit(cmp_data_o, cmp_thr_o) + 1);
            cs_cnt <= 0; cs_acc <= 0;
         end else begin
            cs_acc <= cs_acc*3 + trit(cmp_data_o, cmp_thr_o) + 1;
            cs_cnt <= cs_cnt + 1;
         end
      end
   end

   // Accumulator source plus monitor; samples 2 time units after the falling edge.
   initial begin : drv_mon
      forever begin
         @(negedge clk_i);
         cyc++;
         if (mon_hs && in_q.size() > 0) void'(in_q.pop_front());
         in_valid_i = (in_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
         in_data_i  = (in_q.size() > 0) ? in_q[0] : '0;
         #2;
         mon_hs = rst_ni && in_valid_i && in_ready_o;
         if (rst_ni && cmp_en_o) begin
            cmp_cnt++;
            if (cmp_thr_o == PAD_THR) begin
               pad_cnt++;
               if (cmp_data_o == '0) pad_zero++;
            end
         end
         if (rst_ni && done_o) begin done_cnt++; done_cyc = cyc; end
         if (rst_ni && mem_req_o) req_cnt++;
      end
   end

   // Memory slave with random grant/response latency.
   logic [31:0] ms_a, ms_wd, ms_rd, ms_idx;
   logic        ms_we;
   logic [3:0]  ms_be;
   int          ms_d;
   initial begin : mem_slave
      forever begin
         @(negedge clk_i);
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (rst_ni && mem_req_o) begin
            ms_a = mem_addr_o; ms_we = mem_we_o; ms_be = mem_be_o; ms_wd = mem_wdata_o;
            ms_d = $urandom_range(0, lat_max);
            while (ms_d != 0 && rst_ni) begin
               @(negedge clk_i); ms_d--;
               if (rst_ni)
                  check_eq("req_stable", {mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o},
                           {1'b1, ms_we, ms_a, ms_be, ms_wd});
            end
            if (rst_ni) begin
               mem_gnt_i = 1'b1;
               if (ms_we) st_q.push_back({ms_a, ms_be, ms_wd});
               else begin
                  ld_q.push_back(ms_a);
                  ms_idx = (ms_a - g_thr_eff) >> 2;
                  ms_rd = (ms_idx < 32'(g_n)) ? g_thr[ms_idx[5:0]] : 32'hDEAD_BEEF;
               end
               @(negedge clk_i); mem_gnt_i = 1'b0;
               ms_d = $urandom_range(0, lat_max);
               while (ms_d != 0 && rst_ni) begin
                  check_eq("one_outstanding", mem_req_o, 1'b0);
                  @(negedge clk_i); ms_d--;
               end
               if (rst_ni) begin
                  mem_rdata_i  = ms_we ? 32'h0 : ms_rd;
                  mem_rvalid_i = 1'b1;
               end
            end
         end
      end
   end

   task automatic start_job(input int n, input logic [31:0] tb, input logic [31:0] ob);
      g_n = n; g_thr_eff = tb & ~32'h3; g_out_eff = ob & ~32'h3;
      ld_q.delete(); st_q.delete(); in_q.delete();
      cmp_cnt = 0; pad_cnt = 0; pad_zero = 0; done_cnt = 0; req_cnt = 0;
      for (int i = 0; i < n; i++) begin
         g_dat[i] = 32'($urandom_range(0, 400)) - 32'd200;
         g_thr[i] = {16'($urandom_range(5, 100)), 16'(-$urandom_range(5, 100))};
         in_q.push_back(g_dat[i]);
      end
      @(negedge clk_i);
      start_i = 1'b1; n_act_i = 16'(n); thr_base_i = tb; out_base_i = ob;
      #1 g_t0 = cyc;
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic finish_job(input string name);
      int waited = 0, bad = 0, nbytes, nwords, pads;
      logic [3:0]  be;
      logic [31:0] wd;
      while (done_cnt == 0 && waited < 5000) begin @(negedge clk_i); waited++; end
      check_eq({name, "_no_timeout"}, waited < 5000, 1'b1);
      repeat (4) @(negedge clk_i);
      nbytes = (g_n + 4) / 5;
      nwords = (nbytes + 3) / 4;
      pads   = (5 - g_n % 5) % 5;
      check_eq({name, "_done_once"}, done_cnt, 1);
      check_eq({name, "_idle"}, busy_o, 1'b0);
      check_eq({name, "_loads"}, ld_q.size(), g_n);
      for (int i = 0; i < g_n && i < ld_q.size(); i++)
         if (ld_q[i] != g_thr_eff + 32'(4*i)) bad++;
      check_eq({name, "_load_addr_errs"}, bad, 0);
      check_eq({name, "_cmp_enables"}, cmp_cnt, g_n + pads);
      check_eq({name, "_pads"}, pad_cnt, pads);
      check_eq({name, "_pad_zero_data"}, pad_zero, pad_cnt);
      check_eq({name, "_inputs_drained"}, in_q.size(), 0);
      check_eq({name, "_stores"}, st_q.size(), nwords);
      for (int w = 0; w < nwords && w < st_q.size(); w++) begin
         be = '0; wd = '0;
         for (int l = 0; l < 4; l++)
            if (4*w + l < nbytes) begin
               be[l] = 1'b1;
               wd[8*l +: 8] = exp_byte(4*w + l);
            end
         check_eq($sformatf("%s_store%0d", name, w), st_q[w], {g_out_eff + 32'(4*w), be, wd});
      end
      if (g_n == 0) begin
         check_eq({name, "_done_latency"}, done_cyc - g_t0, 2);
         check_eq({name, "_no_req"}, req_cnt, 0);
      end
   endtask

   initial begin : main
      int found;
      repeat (3) @(negedge clk_i);
      #2;
      check_eq("reset_ctrl", {busy_o, done_o, mem_req_o, mem_we_o, in_ready_o, cmp_en_o}, 6'b0);
      check_eq("reset_mem_bus", {mem_addr_o, mem_be_o, mem_wdata_o}, 68'b0);
      check_eq("reset_cmp_bus", {cmp_data_o, cmp_thr_o}, 64'b0);
      @(negedge clk_i); rst_ni = 1'b1;

      lat_max = 0; gap_pct = 0;
      start_job(5, 32'h0000_1000, 32'h0000_2000);  finish_job("n5");
      start_job(20, 32'h0000_1003, 32'h0000_2002); finish_job("n20");
      start_job(7, 32'h0000_3000, 32'h0000_4000);  finish_job("n7");
      start_job(0, 32'h0000_3000, 32'h0000_4000);  finish_job("n0");

      lat_max = 5; gap_pct = 30;
      start_job(23, 32'hFFFF_FFF3, 32'hFFFF_FFFD); finish_job("wrap");
      for (int j = 0; j < 7; j++) begin
         start_job($urandom_range(1, 40), $urandom, $urandom);
         finish_job($sformatf("rnd%0d", j));
      end

      // Abort a job while its first store is pending, then run a clean job.
      lat_max = 3; gap_pct = 20;
      start_job(25, 32'h0000_5000, 32'h0000_6000);
      found = 0;
      for (int c = 0; c < 3000 && found == 0; c++) begin
         @(negedge clk_i);
         if (mem_req_o && mem_we_o) found = 1;
      end
      check_eq("abort_reached_store", found, 1);
      rst_ni = 1'b0;
      #1 check_eq("abort_outputs", {busy_o, done_o, mem_req_o, in_ready_o, cmp_en_o}, 5'b0);
      repeat (3) @(negedge clk_i);
      in_q.delete();
      check_eq("abort_no_done", done_cnt, 0);
      rst_ni = 1'b1;
      lat_max = 2; gap_pct = 10;
      start_job(5, 32'h0000_7000, 32'h0000_8000); finish_job("after_abort");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
